kamacore_hazard_unit: RTL and testbench

//  Control-side counterpart of the pipeline stage bundle: consumes the register/control fields that stages

---
 rtl/kamacore_pkg.sv | 27 ++
 rtl/kamacore_hazard_unit_if.sv | 56 +++++
 rtl/kamacore_forward_select.sv | 26 ++
 rtl/kamacore_hazard_unit.sv | 122 ++++++++++++
 tb/tb_kamacore_hazard_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/kamacore_pkg.sv
// Shared types for the core's control-side hazard logic.
// Latency: n/a (types, constants and a pure compare helper).
// Backpressure: n/a.
package kamacore_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int CPU_WIDTH      = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

  // Register x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input reg_addr_t a, input reg_addr_t b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/kamacore_hazard_unit_if.sv
// Bundle of stage fields flowing into the hazard unit and the controls it drives back.
// Latency: n/a (wiring only).
// Backpressure: hold/bubble outputs are the pipeline's stall controls.
interface kamacore_hazard_unit_if #(
  parameter int STALL_CNT_WIDTH = 16
);
  import kamacore_pkg::*;

  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_uses_rs1;
  logic      id_uses_rs2;
  reg_addr_t ex_rs1;
  reg_addr_t ex_rs2;
  reg_addr_t ex_destination_register;
  logic      ex_control_write_register;
  logic      ex_control_memory_read;
  reg_addr_t mem_destination_register;
  logic      mem_control_write_register;
  logic      mem_control_memory_read;
  logic      mem_control_memory_write;
  logic      mem_ready;
  reg_addr_t wb_destination_register;
  logic      wb_control_write_register;

  logic      hold_front;
  logic      bubble_ex;
  logic      hold_all;
  fwd_sel_t  forward_a_sel;
  fwd_sel_t  forward_b_sel;
  logic      mem_timeout_error;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  // Pipeline side: drives stage fields, consumes stall/forward controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_destination_register, ex_control_write_register, ex_control_memory_read,
    output mem_destination_register, mem_control_write_register,
    output mem_control_memory_read, mem_control_memory_write, mem_ready,
    output wb_destination_register, wb_control_write_register,
    input  hold_front, bubble_ex, hold_all, forward_a_sel, forward_b_sel,
    input  mem_timeout_error, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_destination_register, ex_control_write_register, ex_control_memory_read,
    input  mem_destination_register, mem_control_write_register,
    input  mem_control_memory_read, mem_control_memory_write, mem_ready,
    input  wb_destination_register, wb_control_write_register,
    output hold_front, bubble_ex, hold_all, forward_a_sel, forward_b_sel,
    output mem_timeout_error, stall_count
  );

endinterface

// File: rtl/kamacore_forward_select.sv
// Priority forwarding select for one EX source operand (MEM result beats WB value).
// Latency: combinational, 0 cycles.
// Backpressure: none; a load in MEM has no result yet and is never a MEM forward source.
module kamacore_forward_select
  import kamacore_pkg::*;
(
  input  reg_addr_t src,
  input  reg_addr_t mem_rd,
  input  logic      mem_wr,
  input  logic      mem_ld,
  input  reg_addr_t wb_rd,
  input  logic      wb_wr,
  output fwd_sel_t  sel
);

  // Youngest producer wins; x0 is filtered inside reg_match.
  always_comb begin
    sel = FWD_NONE;
    if (mem_wr && !mem_ld && reg_match(src, mem_rd)) begin
      sel = FWD_MEM;
    end else if (wb_wr && reg_match(src, wb_rd)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/kamacore_hazard_unit.sv
// Pipeline hazard control: load-use bubble, data-memory wait freeze, EX operand forwarding.
// Latency: all controls combinational (0 cycles); error flag and stall counter registered.
// Backpressure: hold_all freezes every stage while memory is busy; hold_front+bubble_ex for load-use.
module kamacore_hazard_unit
  import kamacore_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 64,
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  kamacore_hazard_unit_if.slave bus
);

  localparam int WCNT = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT-1:0] TIMEOUT_V = WCNT'(MEM_TIMEOUT);

  hazard_state_t state_q, state_d;
  logic [WCNT-1:0] wait_q, wait_d;
  logic            err_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  logic     mem_req, mem_stall, load_use;
  logic     hold_front_c, bubble_c, hold_all_c;
  fwd_sel_t fwd_a, fwd_b;

  assign mem_req   = bus.mem_control_memory_read | bus.mem_control_memory_write;
  assign mem_stall = mem_req & ~bus.mem_ready;

  // A load in EX whose rd is read by the instruction in decode needs one bubble.
  assign load_use = bus.ex_control_memory_read && bus.ex_control_write_register &&
                    ((bus.id_uses_rs1 && reg_match(bus.ex_destination_register, bus.id_rs1)) ||
                     (bus.id_uses_rs2 && reg_match(bus.ex_destination_register, bus.id_rs2)));

  kamacore_forward_select u_fwd_a (
    .src    (bus.ex_rs1),
    .mem_rd (bus.mem_destination_register),
    .mem_wr (bus.mem_control_write_register),
    .mem_ld (bus.mem_control_memory_read),
    .wb_rd  (bus.wb_destination_register),
    .wb_wr  (bus.wb_control_write_register),
    .sel    (fwd_a)
  );

  kamacore_forward_select u_fwd_b (
    .src    (bus.ex_rs2),
    .mem_rd (bus.mem_destination_register),
    .mem_wr (bus.mem_control_write_register),
    .mem_ld (bus.mem_control_memory_read),
    .wb_rd  (bus.wb_destination_register),
    .wb_wr  (bus.wb_control_write_register),
    .sel    (fwd_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state and wait counter; the counter saturates so the timeout stays visible.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WCNT'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q != TIMEOUT_V) begin
          wait_d  = wait_q + WCNT'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Stall controls: a memory freeze overrides the bubble; load-use is re-checked after release.
  always_comb begin
    hold_all_c   = 1'b0;
    hold_front_c = 1'b0;
    bubble_c     = 1'b0;
    if (!rst) begin
      hold_all_c   = mem_stall;
      hold_front_c = mem_stall | load_use;
      bubble_c     = load_use & ~mem_stall;
    end
  end

  // Wait counter, sticky timeout flag and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_q | (wait_d == TIMEOUT_V);
      if ((hold_front_c || hold_all_c) && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_CNT_WIDTH'(1);
      end
    end
  end

  assign bus.hold_all          = hold_all_c;
  assign bus.hold_front        = hold_front_c;
  assign bus.bubble_ex         = bubble_c;
  assign bus.forward_a_sel     = rst ? FWD_NONE : fwd_a;
  assign bus.forward_b_sel     = rst ? FWD_NONE : fwd_b;
  assign bus.mem_timeout_error = rst ? 1'b0 : err_q;
  assign bus.stall_count       = rst ? '0 : stall_q;

endmodule

// File: tb/tb_kamacore_hazard_unit.sv
// Directed bench for kamacore_hazard_unit: vector table plus multi-cycle wait/reset sequences.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later or after rising edge.
// Backpressure: mem_ready driven directly to create wait and timeout scenarios.
module tb_kamacore_hazard_unit;
  import kamacore_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  kamacore_hazard_unit_if hif ();

  kamacore_hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       u1, u2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_wr, ex_ld;
    logic [4:0] mem_rd;
    logic       mem_wr, mem_ld;
    logic [4:0] wb_rd;
    logic       wb_wr;
    logic       hf, bub;
    fwd_sel_t   fa, fb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_uses_rs1 = 0; hif.id_uses_rs2 = 0;
    hif.ex_rs1 = '0; hif.ex_rs2 = '0; hif.ex_destination_register = '0;
    hif.ex_control_write_register = 0; hif.ex_control_memory_read = 0;
    hif.mem_destination_register = '0; hif.mem_control_write_register = 0;
    hif.mem_control_memory_read = 0; hif.mem_control_memory_write = 0; hif.mem_ready = 1;
    hif.wb_destination_register = '0; hif.wb_control_write_register = 0;
  endtask

  task automatic apply(input vec_t v);
    hif.id_rs1 = v.id_rs1; hif.id_rs2 = v.id_rs2;
    hif.id_uses_rs1 = v.u1; hif.id_uses_rs2 = v.u2;
    hif.ex_rs1 = v.ex_rs1; hif.ex_rs2 = v.ex_rs2; hif.ex_destination_register = v.ex_rd;
    hif.ex_control_write_register = v.ex_wr; hif.ex_control_memory_read = v.ex_ld;
    hif.mem_destination_register = v.mem_rd; hif.mem_control_write_register = v.mem_wr;
    hif.mem_control_memory_read = v.mem_ld; hif.mem_control_memory_write = 0; hif.mem_ready = 1;
    hif.wb_destination_register = v.wb_rd; hif.wb_control_write_register = v.wb_wr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        id1    id2    u1 u2 exs1   exs2   exrd   wr ld memrd  wr ld wbrd   wr hf bub fa        fb
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd5, 5'd6, 5'd0, 0, 0, 5'd5, 1, 0, 5'd0, 0, 0, 0, FWD_MEM,  FWD_NONE};
    vecs[1]  = '{5'd0, 5'd0, 0, 0, 5'd5, 5'd6, 5'd0, 0, 0, 5'd5, 1, 0, 5'd5, 1, 0, 0, FWD_MEM,  FWD_NONE};
    vecs[2]  = '{5'd0, 5'd0, 0, 0, 5'd1, 5'd7, 5'd0, 0, 0, 5'd7, 1, 1, 5'd7, 1, 0, 0, FWD_NONE, FWD_WB};
    vecs[3]  = '{5'd0, 5'd0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 5'd0, 1, 0, 0, FWD_NONE, FWD_NONE};
    vecs[4]  = '{5'd0, 5'd0, 0, 0, 5'd9, 5'd9, 5'd0, 0, 0, 5'd0, 0, 0, 5'd9, 1, 0, 0, FWD_WB,   FWD_WB};
    vecs[5]  = '{5'd0, 5'd0, 0, 0, 5'd4, 5'd0, 5'd0, 0, 0, 5'd4, 0, 0, 5'd4, 1, 0, 0, FWD_WB,   FWD_NONE};
    vecs[6]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0, 5'd0, 0, 0, 5'd8, 0, 0, 0, FWD_NONE, FWD_NONE};
    vecs[7]  = '{5'd1, 5'd12,1, 1, 5'd0, 5'd0, 5'd12,1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 1, FWD_NONE, FWD_NONE};
    vecs[8]  = '{5'd3, 5'd0, 0, 1, 5'd0, 5'd0, 5'd3, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, FWD_NONE, FWD_NONE};
    vecs[9]  = '{5'd3, 5'd0, 1, 0, 5'd0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, FWD_NONE, FWD_NONE};
    vecs[10] = '{5'd3, 5'd0, 1, 0, 5'd0, 5'd0, 5'd3, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, FWD_NONE, FWD_NONE};
    vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd2, 5'd3, 5'd0, 0, 0, 5'd2, 1, 0, 5'd3, 1, 0, 0, FWD_MEM,  FWD_WB};

    // Reset: outputs stay quiet even with a load-use pattern and a pending access present.
    idle();
    hif.ex_control_memory_read = 1; hif.ex_control_write_register = 1;
    hif.ex_destination_register = 5'd3; hif.id_rs1 = 5'd3; hif.id_uses_rs1 = 1;
    hif.ex_rs1 = 5'd3; hif.wb_destination_register = 5'd3; hif.wb_control_write_register = 1;
    hif.mem_control_memory_read = 1; hif.mem_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_hold_front", int'(hif.hold_front), 0);
    check("rst_bubble", int'(hif.bubble_ex), 0);
    check("rst_hold_all", int'(hif.hold_all), 0);
    check("rst_fwd_a", int'(hif.forward_a_sel), int'(FWD_NONE));
    check("rst_err", int'(hif.mem_timeout_error), 0);
    check("rst_stall", int'(hif.stall_count), 0);
    @(negedge clk); rst = 0; idle(); #1;
    check("post_rst_stall", int'(hif.stall_count), 0);

    // Load-use for one cycle, then the load has moved to MEM and no repeat occurs.
    @(negedge clk);
    hif.ex_control_memory_read = 1; hif.ex_control_write_register = 1;
    hif.ex_destination_register = 5'd3; hif.id_rs1 = 5'd3; hif.id_uses_rs1 = 1; #1;
    check("lu_hold_front", int'(hif.hold_front), 1);
    check("lu_bubble", int'(hif.bubble_ex), 1);
    check("lu_hold_all", int'(hif.hold_all), 0);
    exp_stall++;
    @(negedge clk); idle();
    hif.mem_destination_register = 5'd3; hif.mem_control_write_register = 1;
    hif.mem_control_memory_read = 1; hif.mem_ready = 1; #1;
    check("lu_next_hold_front", int'(hif.hold_front), 0);
    check("lu_next_bubble", int'(hif.bubble_ex), 0);
    check("lu_stall_count", int'(hif.stall_count), exp_stall);

    // Vector table: forwarding priorities, x0 filtering, load-use qualifiers.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); apply(vecs[i]); #1;
      check($sformatf("vec%0d_hold_front", i), int'(hif.hold_front), int'(vecs[i].hf));
      check($sformatf("vec%0d_bubble", i), int'(hif.bubble_ex), int'(vecs[i].bub));
      check($sformatf("vec%0d_hold_all", i), int'(hif.hold_all), 0);
      check($sformatf("vec%0d_fwd_a", i), int'(hif.forward_a_sel), int'(vecs[i].fa));
      check($sformatf("vec%0d_fwd_b", i), int'(hif.forward_b_sel), int'(vecs[i].fb));
      if (vecs[i].hf) exp_stall++;
    end
    @(negedge clk); idle(); #1;
    check("table_stall_count", int'(hif.stall_count), exp_stall);

    // Memory wait for 3 cycles with a load-use also present: freeze beats bubble.
    hif.mem_control_memory_read = 1; hif.mem_control_write_register = 1;
    hif.mem_destination_register = 5'd3; hif.mem_ready = 0;
    hif.ex_control_memory_read = 1; hif.ex_control_write_register = 1;
    hif.ex_destination_register = 5'd6; hif.id_rs1 = 5'd6; hif.id_uses_rs1 = 1;
    hif.ex_rs1 = 5'd3; hif.wb_destination_register = 5'd3; hif.wb_control_write_register = 1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      check($sformatf("wait%0d_hold_all", i), int'(hif.hold_all), 1);
      check($sformatf("wait%0d_hold_front", i), int'(hif.hold_front), 1);
      check($sformatf("wait%0d_bubble", i), int'(hif.bubble_ex), 0);
      check($sformatf("wait%0d_fwd_a", i), int'(hif.forward_a_sel), int'(FWD_WB));
      check($sformatf("wait%0d_state", i), int'(dut.state_q), (i == 0) ? int'(RUN) : int'(MEM_WAIT));
      exp_stall++;
    end
    @(negedge clk); hif.mem_ready = 1; #1;
    check("release_hold_all", int'(hif.hold_all), 0);
    check("release_hold_front", int'(hif.hold_front), 1);
    check("release_bubble", int'(hif.bubble_ex), 1);
    exp_stall++;
    @(negedge clk); idle(); #1;
    check("release_state", int'(dut.state_q), int'(RUN));
    check("wait_stall_count", int'(hif.stall_count), exp_stall);
    check("wait_no_err", int'(hif.mem_timeout_error), 0);

    // Timeout: flag rises exactly when 64 wait cycles have elapsed and then stays.
    @(negedge clk); hif.mem_control_memory_read = 1; hif.mem_ready = 0;
    repeat (63) @(posedge clk);
    #1;
    check("timeout_63_err", int'(hif.mem_timeout_error), 0);
    check("timeout_63_hold_all", int'(hif.hold_all), 1);
    @(posedge clk); #1;
    check("timeout_64_err", int'(hif.mem_timeout_error), 1);
    exp_stall += 64;
    @(negedge clk); hif.mem_ready = 1;
    @(negedge clk); idle(); #1;
    check("timeout_sticky_err", int'(hif.mem_timeout_error), 1);
    check("timeout_state", int'(dut.state_q), int'(RUN));
    check("timeout_stall_count", int'(hif.stall_count), exp_stall);

    // Reset in the middle of a wait clears state, counters and error.
    hif.mem_control_memory_write = 1; hif.mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("midwait_state", int'(dut.state_q), int'(MEM_WAIT));
    @(negedge clk); rst = 1; #1;
    check("midrst_hold_all", int'(hif.hold_all), 0);
    check("midrst_hold_front", int'(hif.hold_front), 0);
    @(posedge clk); #1;
    check("midrst_state", int'(dut.state_q), int'(RUN));
    check("midrst_stall", int'(hif.stall_count), 0);
    @(negedge clk); rst = 0; idle(); #1;
    check("after_rst_err", int'(hif.mem_timeout_error), 0);
    check("after_rst_stall", int'(hif.stall_count), 0);
    check("after_rst_hold_all", int'(hif.hold_all), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
